vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, syncs, blanking and a 1-cycle colour pipeline.
// Optional colour-bar test pattern is built only when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned COLOR_W  = 10
) (
   input  logic               CLK_PIX,
   input  logic               nRst,
   input  logic [COLOR_W-1:0] iRed,
   input  logic [COLOR_W-1:0] iGreen,
   input  logic [COLOR_W-1:0] iBlue,
   input  logic               iPattern,
   output logic               VGA_CLK,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC,
   output logic [COLOR_W-1:0] VGA_R,
   output logic [COLOR_W-1:0] VGA_G,
   output logic [COLOR_W-1:0] VGA_B,
   output logic [31:0]        oX,
   output logic [31:0]        oY,
   output logic               oImValid,
   output logic               oFrameStart,
   output logic               oLineStart
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_W      = $clog2(H_TOTAL);
   localparam int unsigned V_W      = $clog2(V_TOTAL);
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [H_W-1:0]     h_cnt, h_nxt;
   logic [V_W-1:0]     v_cnt, v_nxt;
   logic               act_nxt, hs_act, vs_act;
   logic [COLOR_W-1:0] red_src, green_src, blue_src;

   assign VGA_CLK  = ~CLK_PIX;
   assign VGA_SYNC = 1'b0;

   // Next raster position; vertical advances only on the horizontal wrap
   always_comb begin
      h_nxt = h_cnt + H_W'(1);
      v_nxt = v_cnt;
      if (32'(h_cnt) == H_TOTAL - 1) begin
         h_nxt = '0;
         v_nxt = (32'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + V_W'(1);
      end
   end

   assign act_nxt = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
   assign hs_act  = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
   assign vs_act  = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar;

   // Eight equal bars across the active width; only meaningful while active
   assign bar = 3'((32'(h_cnt) << 3) / H_ACTIVE);

   always_comb begin
      red_src   = iRed;
      green_src = iGreen;
      blue_src  = iBlue;
      if (iPattern) begin
         red_src   = {COLOR_W{bar[0]}};
         green_src = {COLOR_W{bar[1]}};
         blue_src  = {COLOR_W{bar[2]}};
      end
   end
`else
   logic unused_pattern;

   assign unused_pattern = iPattern;
   assign red_src        = iRed;
   assign green_src      = iGreen;
   assign blue_src       = iBlue;
`endif

   // Counters and coordinate outputs; reset parks one step before (0,0)
   always_ff @(posedge CLK_PIX) begin
      if (!nRst) begin
         h_cnt       <= H_W'(H_TOTAL - 1);
         v_cnt       <= V_W'(V_TOTAL - 1);
         oX          <= '0;
         oY          <= '0;
         oImValid    <= 1'b0;
         oFrameStart <= 1'b0;
         oLineStart  <= 1'b0;
      end else begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         oX          <= 32'(h_nxt);
         oY          <= 32'(v_nxt);
         oImValid    <= act_nxt;
         oFrameStart <= (h_nxt == '0) && (v_nxt == '0);
         oLineStart  <= (h_nxt == '0);
      end
   end

   // DAC stage: colour for the current coordinate plus syncs delayed to match
   always_ff @(posedge CLK_PIX) begin
      if (!nRst) begin
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         VGA_BLANK <= 1'b0;
         VGA_HS    <= ~HS_POL;
         VGA_VS    <= ~VS_POL;
      end else begin
         VGA_R     <= oImValid ? red_src   : '0;
         VGA_G     <= oImValid ? green_src : '0;
         VGA_B     <= oImValid ? blue_src  : '0;
         VGA_BLANK <= oImValid;
         VGA_HS    <= hs_act ? HS_POL : ~HS_POL;
         VGA_VS    <= vs_act ? VS_POL : ~VS_POL;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x525 timing (partial frame) and a tiny 12x7 override.
module tb_vga_timing_gen;

   localparam int CW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a_n, rst_b_n, pat;
   logic [CW-1:0] a_ired, a_igrn, a_iblu, b_ired, b_igrn, b_iblu;

   logic          a_vclk, a_hs, a_vs, a_blank, a_sync, a_valid, a_fs, a_ls;
   logic [CW-1:0] a_r, a_g, a_b;
   logic [31:0]   a_x, a_y;
   logic          b_vclk, b_hs, b_vs, b_blank, b_sync, b_valid, b_fs, b_ls;
   logic [CW-1:0] b_r, b_g, b_b;
   logic [31:0]   b_x, b_y;

   int n_chk  = 0;
   int n_pass = 0;

   vga_timing_gen u_big (
      .CLK_PIX(clk), .nRst(rst_a_n), .iRed(a_ired), .iGreen(a_igrn), .iBlue(a_iblu),
      .iPattern(pat), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK(a_blank),
      .VGA_SYNC(a_sync), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .oX(a_x), .oY(a_y),
      .oImValid(a_valid), .oFrameStart(a_fs), .oLineStart(a_ls)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
   ) u_small (
      .CLK_PIX(clk), .nRst(rst_b_n), .iRed(b_ired), .iGreen(b_igrn), .iBlue(b_iblu),
      .iPattern(1'b0), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK(b_blank),
      .VGA_SYNC(b_sync), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .oX(b_x), .oY(b_y),
      .oImValid(b_valid), .oFrameStart(b_fs), .oLineStart(b_ls)
   );

   task automatic test_reset();
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({a_x, a_y, a_valid, a_fs, a_ls} !== 67'd0)
         $display("FAIL reset_coords_a got %h exp 0", {a_x, a_y, a_valid, a_fs, a_ls});
      else n_pass++;
      n_chk++;
      if ({a_blank, a_hs, a_vs, a_r, a_g, a_b} !== {3'b011, 30'd0})
         $display("FAIL reset_video_a got %h exp %h", {a_blank, a_hs, a_vs, a_r, a_g, a_b}, {3'b011, 30'd0});
      else n_pass++;
      n_chk++;
      if ({b_blank, b_hs, b_vs, b_r, b_g, b_b} !== {3'b001, 30'd0})
         $display("FAIL reset_video_b got %h exp %h", {b_blank, b_hs, b_vs, b_r, b_g, b_b}, {3'b001, 30'd0});
      else n_pass++;
      n_chk++;
      if ({a_sync, b_sync, a_vclk, b_vclk} !== 4'b0000)
         $display("FAIL sync_vclk_high got %b exp 0000", {a_sync, b_sync, a_vclk, b_vclk});
      else n_pass++;
      @(negedge clk);
      #1;
      n_chk++;
      if ({a_vclk, b_vclk} !== 2'b11)
         $display("FAIL vclk_low_phase got %b exp 11", {a_vclk, b_vclk});
      else n_pass++;
   endtask

   // Default timing: release reset and follow lines 0..2 cycle by cycle
   task automatic test_big_run(input int ncyc);
      int mx, my, nfs, nls, nv;
      logic pv, ph, pvs, ev;
      logic [CW-1:0] pr, pg, pb;
      logic [66:0] ec;
      logic [32:0] evid;
      mx = 0; my = 0; pv = 1'b0; ph = 1'b0; pvs = 1'b0;
      pr = '0; pg = '0; pb = '0; nfs = 0; nls = 0; nv = 0;
      @(posedge clk);
      #1;
      rst_a_n = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         ev   = (mx < 640) && (my < 480);
         ec   = {32'(mx), 32'(my), ev, (mx == 0) && (my == 0), mx == 0};
         evid = {pv, ~ph, ~pvs, pv ? pr : 10'd0, pv ? pg : 10'd0, pv ? pb : 10'd0};
         n_chk++;
         if ({a_x, a_y, a_valid, a_fs, a_ls} !== ec)
            $display("FAIL big_coords cyc=%0d got %h exp %h", i, {a_x, a_y, a_valid, a_fs, a_ls}, ec);
         else n_pass++;
         n_chk++;
         if ({a_blank, a_hs, a_vs, a_r, a_g, a_b} !== evid)
            $display("FAIL big_video cyc=%0d got %h exp %h", i, {a_blank, a_hs, a_vs, a_r, a_g, a_b}, evid);
         else n_pass++;
         nfs += int'(a_fs);
         nls += int'(a_ls);
         nv  += int'(a_valid);
         a_ired = 10'd511;
         a_igrn = CW'(mx);
         a_iblu = CW'(mx * 3 + my);
         pv  = ev;
         ph  = (mx >= 656) && (mx < 752);
         pvs = (my >= 490) && (my < 492);
         pr  = a_ired; pg = a_igrn; pb = a_iblu;
         mx++;
         if (mx == 800) begin
            mx = 0;
            my = (my == 524) ? 0 : my + 1;
         end
      end
      n_chk++;
      if ({nfs, nls, nv} !== {32'd1, 32'd3, 32'd1380})
         $display("FAIL big_counts got fs=%0d ls=%0d valid=%0d exp 1 3 1380", nfs, nls, nv);
      else n_pass++;
   endtask

   // 12x7 override: three full frames, HS active-high at h 9..10, VS low on line 5
   task automatic test_small_run(input int ncyc);
      int mx, my, nfs, nls, nv;
      logic pv, ph, pvs, ev;
      logic [CW-1:0] pr, pg, pb;
      logic [66:0] ec;
      logic [32:0] evid;
      mx = 0; my = 0; pv = 1'b0; ph = 1'b0; pvs = 1'b0;
      pr = '0; pg = '0; pb = '0; nfs = 0; nls = 0; nv = 0;
      rst_b_n = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         ev   = (mx < 8) && (my < 4);
         ec   = {32'(mx), 32'(my), ev, (mx == 0) && (my == 0), mx == 0};
         evid = {pv, ph, ~pvs, pv ? pr : 10'd0, pv ? pg : 10'd0, pv ? pb : 10'd0};
         n_chk++;
         if ({b_x, b_y, b_valid, b_fs, b_ls} !== ec)
            $display("FAIL small_coords cyc=%0d got %h exp %h", i, {b_x, b_y, b_valid, b_fs, b_ls}, ec);
         else n_pass++;
         n_chk++;
         if ({b_blank, b_hs, b_vs, b_r, b_g, b_b} !== evid)
            $display("FAIL small_video cyc=%0d got %h exp %h", i, {b_blank, b_hs, b_vs, b_r, b_g, b_b}, evid);
         else n_pass++;
         nfs += int'(b_fs);
         nls += int'(b_ls);
         nv  += int'(b_valid);
         b_ired = CW'(mx + 16 * my);
         b_igrn = ~b_ired;
         b_iblu = CW'(i);
         pv  = ev;
         ph  = (mx >= 9) && (mx < 11);
         pvs = (my == 5);
         pr  = b_ired; pg = b_igrn; pb = b_iblu;
         mx++;
         if (mx == 12) begin
            mx = 0;
            my = (my == 6) ? 0 : my + 1;
         end
      end
      n_chk++;
      if ({nfs, nls, nv} !== {32'd3, 32'd21, 32'd96})
         $display("FAIL small_counts got fs=%0d ls=%0d valid=%0d exp 3 21 96", nfs, nls, nv);
      else n_pass++;
   endtask

   // Reset asserted mid-line must take effect at once and restart at (0,0)
   task automatic test_midframe_reset();
      int k;
      k = 0;
      while (k < 1000 && a_x != 32'd300) begin
         @(posedge clk);
         #1;
         k++;
      end
      n_chk++;
      if (a_x !== 32'd300) $display("FAIL big_wait_300 got %0d exp 300", a_x);
      else n_pass++;
      rst_a_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if ({a_x, a_y, a_valid, a_fs, a_ls, a_blank, a_hs, a_vs, a_r, a_g, a_b} !== {70'd0, 1'b1, 1'b1, 30'd0})
            $display("FAIL big_midreset cyc=%0d got x=%0d y=%0d v=%b hs=%b vs=%b r=%0d", i, a_x, a_y, a_valid, a_hs, a_vs, a_r);
         else n_pass++;
      end
      rst_a_n = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({a_x, a_y, a_valid, a_fs, a_ls, a_blank, a_hs, a_vs} !== {64'd0, 3'b111, 3'b011})
         $display("FAIL big_after_release got x=%0d y=%0d v=%b fs=%b ls=%b blank=%b", a_x, a_y, a_valid, a_fs, a_ls, a_blank);
      else n_pass++;

      b_ired = 10'd7; b_igrn = 10'd8; b_iblu = 10'd9;
      k = 0;
      while (k < 200 && !(b_x == 32'd5 && b_y == 32'd2)) begin
         @(posedge clk);
         #1;
         k++;
      end
      n_chk++;
      if ({b_x, b_y} !== {32'd5, 32'd2}) $display("FAIL small_wait_5_2 got (%0d,%0d) exp (5,2)", b_x, b_y);
      else n_pass++;
      rst_b_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if ({b_x, b_y, b_valid, b_fs, b_ls, b_blank, b_hs, b_vs, b_r} !== {70'd0, 1'b0, 1'b1, 10'd0})
            $display("FAIL small_midreset cyc=%0d got x=%0d y=%0d hs=%b vs=%b blank=%b", i, b_x, b_y, b_hs, b_vs, b_blank);
         else n_pass++;
      end
      rst_b_n = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({b_x, b_y, b_valid, b_fs, b_ls, b_blank, b_hs, b_vs, b_r} !== {64'd0, 3'b111, 3'b001, 10'd0})
         $display("FAIL small_after_release got x=%0d y=%0d v=%b fs=%b blank=%b r=%0d", b_x, b_y, b_valid, b_fs, b_blank, b_r);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++;
      if ({b_x, b_blank, b_r, b_g, b_b} !== {32'd1, 1'b1, 10'd7, 10'd8, 10'd9})
         $display("FAIL small_first_pixel got x=%0d blank=%b rgb=%0d,%0d,%0d exp 1 1 7,8,9", b_x, b_blank, b_r, b_g, b_b);
      else n_pass++;
   endtask

   // Colour bars when the pattern is built; otherwise iPattern must be ignored
   task automatic test_pattern();
      int px;
      logic [29:0] erg;
      rst_a_n = 1'b0;
      @(posedge clk);
      #1;
      rst_a_n = 1'b1;
      pat = 1'b1;
      a_ired = 10'd5; a_igrn = 10'd6; a_iblu = 10'd7;
      for (int i = 0; i < 660; i++) begin
         @(posedge clk);
         #1;
         px = i - 1;
         if (px == 0 || px == 80 || px == 560 || px == 640) begin
`ifdef VGA_TEST_PATTERN_EN
            case (px)
               80:      erg = {10'd1023, 10'd0, 10'd0};
               560:     erg = {10'd1023, 10'd1023, 10'd1023};
               default: erg = 30'd0;
            endcase
`else
            erg = (px == 640) ? 30'd0 : {10'd5, 10'd6, 10'd7};
`endif
            n_chk++;
            if ({a_r, a_g, a_b} !== erg)
               $display("FAIL pattern_px%0d got %0d,%0d,%0d exp %h", px, a_r, a_g, a_b, erg);
            else n_pass++;
         end
      end
      pat = 1'b0;
   endtask

   initial begin
      pat = 1'b0;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      a_ired = '0; a_igrn = '0; a_iblu = '0;
      b_ired = '0; b_igrn = '0; b_iblu = '0;
      test_reset();
      test_big_run(1700);
      test_small_run(252);
      test_midframe_reset();
      test_pattern();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
